// File: rtl/imem_arbiter.sv
// Arbitrates the single-port instruction memory between CPU fetch (read) and the program loader (write).
// Optional fetch range checking is enabled by defining IMEM_RANGE_CHECK_EN.
module imem_arbiter #(
    parameter int unsigned AW           = 6,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_pc,
    output logic [31:0]   fetch_instr,
    output logic          fetch_valid,
    output logic          fetch_fault,
    output logic          cpu_hold,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    output logic          ld_ack,
    input  logic          ld_done,
    output logic [AW:0]   ld_count,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int unsigned CW    = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned CNTW  = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic {BOOT, RUN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] starve_cnt, starve_cnt_nx;
    logic          ld_gnt;
    logic          fetch_gnt;
    logic          forced;
    logic          fetch_oor;
    logic          unused_pc_bits;

    // State and starvation counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            starve_cnt <= '0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_cnt_nx;
        end
    end

    // Next state, grant selection and CPU hold
    always_comb begin
        state_nx      = state;
        starve_cnt_nx = starve_cnt;
        ld_gnt        = 1'b0;
        fetch_gnt     = 1'b0;
        forced        = 1'b0;
        cpu_hold      = 1'b1;
        case (state)
            BOOT: begin
                ld_gnt = ld_req;
                if (ld_done) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                forced    = ld_req && fetch_req && (starve_cnt == CW'(STARVE_LIMIT));
                ld_gnt    = ld_req && (!fetch_req || forced);
                fetch_gnt = fetch_req && !forced;
                cpu_hold  = forced;
            end
            default: state_nx = BOOT;
        endcase
        // Counter only runs while the loader is being denied in favour of fetch
        if (ld_gnt || !ld_req) begin
            starve_cnt_nx = '0;
        end else if (fetch_req) begin
            starve_cnt_nx = starve_cnt + CW'(1);
        end
    end

    // Memory port drive follows the grant
    always_comb begin
        mem_addr = '0;
        mem_we   = 1'b0;
        if (ld_gnt) begin
            mem_addr = ld_addr;
            mem_we   = 1'b1;
        end else if (fetch_gnt) begin
            mem_addr = fetch_pc[AW+1:2];
        end
    end

    assign mem_wdata = ld_data;

`ifdef IMEM_RANGE_CHECK_EN
    assign fetch_oor = |fetch_pc[31:AW+2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_fault <= 1'b0;
        end else begin
            fetch_fault <= fetch_gnt && fetch_oor;
        end
    end
`else
    assign fetch_oor   = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // Byte offset never matters; upper bits only matter with range checking
    assign unused_pc_bits = ^{fetch_pc[31:AW+2], fetch_pc[1:0]};

    // Registered fetch response and loader acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_instr <= NOP_WORD;
            fetch_valid <= 1'b0;
            ld_ack      <= 1'b0;
            ld_count    <= '0;
        end else begin
            fetch_valid <= fetch_gnt;
            ld_ack      <= ld_gnt;
            if (fetch_gnt) begin
                fetch_instr <= fetch_oor ? NOP_WORD : mem_rdata;
            end
            if (ld_gnt && (ld_count != CNTW'(DEPTH))) begin
                ld_count <= ld_count + CNTW'(1);
            end
        end
    end

endmodule
